// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller at the commit point.
//
// Takes one committing instruction per cycle with its exception vector,
// picks the highest-priority exception or enabled timer interrupt (or mret),
// updates the machine trap CSRs and then sequences a pipeline flush followed
// by a one-cycle fetch redirect to the trap vector (or to mepc for mret).
//
// Configuration macro: TRAP_VECTORED_EN
//   defined   - mtvec[1:0] writable (MODE 1 = vectored), interrupts go to
//               BASE + 4*cause
//   undefined - mtvec[1:0] hardwired to 0, every trap goes to BASE
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   commit_valid/ready        commit handshake
//   commit_pc/except/tval     committing instruction PC, exception flags, tval
//   csr_we/addr/wdata         CSR write port
//   csr_rdata                 combinational CSR read (0 if unmapped)
//   flush_req/flush_ack       pipeline flush handshake
//   redirect_valid/pc         one-cycle fetch redirect

package trap_ctrl_pkg;

    // Per-instruction exception flags; first member is the MSB.
    typedef struct packed {
        logic timer_int;
        logic breakpoint;
        logic fetch_pagefault;
        logic fetch_access_fault;
        logic illegal_inst;
        logic sret;
        logic uret;
        logic fetch_misalign;
        logic ecall;
        logic load_misalign;
        logic store_misalign;
        logic load_pagefault;
        logic store_pagefault;
        logic load_access_fault;
        logic store_access_fault;
        logic mret;
    } except_t;

endpackage

module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_MTVEC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    output logic            commit_ready,
    input  logic [XLEN-1:0] commit_pc,
    input  except_t         commit_except,
    input  logic [XLEN-1:0] commit_tval,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            flush_req,
    input  logic            flush_ack,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    state_t state, state_next;

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_mtie;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            timer_en;
    logic            exc_any;
    logic            accept;
    logic            take_trap;
    logic            take_mret;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_tval;
    logic            trap_irq;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] mtvec_wval;

    // ------------------------------------------------------------------
    // Event selection
    // ------------------------------------------------------------------
    assign timer_en = commit_except.timer_int & mstatus_mie & mie_mtie;
    assign exc_any  = commit_except.breakpoint        | commit_except.fetch_pagefault   |
                      commit_except.fetch_access_fault | commit_except.illegal_inst      |
                      commit_except.sret              | commit_except.uret              |
                      commit_except.fetch_misalign    | commit_except.ecall             |
                      commit_except.load_misalign     | commit_except.store_misalign    |
                      commit_except.load_pagefault    | commit_except.store_pagefault   |
                      commit_except.load_access_fault | commit_except.store_access_fault;

    // Derived from state directly so the FSM comb block has no loop through commit_ready.
    assign accept    = commit_valid & (state == S_IDLE) & ~rst;
    assign take_trap = accept & (timer_en | exc_any);
    assign take_mret = accept & commit_except.mret & ~timer_en & ~exc_any;

    always_comb begin
        trap_cause = '0;
        trap_tval  = commit_tval;
        trap_irq   = 1'b0;
        if (timer_en) begin
            trap_cause = {1'b1, (XLEN-1)'(7)};
            trap_tval  = '0;
            trap_irq   = 1'b1;
        end else if (commit_except.breakpoint) begin
            trap_cause = XLEN'(3);
            trap_tval  = commit_pc;
        end else if (commit_except.fetch_pagefault) begin
            trap_cause = XLEN'(12);
        end else if (commit_except.fetch_access_fault) begin
            trap_cause = XLEN'(1);
        end else if (commit_except.illegal_inst | commit_except.sret | commit_except.uret) begin
            trap_cause = XLEN'(2);
            // Only a genuine illegal instruction carries instruction bits.
            if (!commit_except.illegal_inst) begin
                trap_tval = '0;
            end
        end else if (commit_except.fetch_misalign) begin
            trap_cause = XLEN'(0);
        end else if (commit_except.ecall) begin
            trap_cause = XLEN'(11);
            trap_tval  = '0;
        end else if (commit_except.load_misalign) begin
            trap_cause = XLEN'(4);
        end else if (commit_except.store_misalign) begin
            trap_cause = XLEN'(6);
        end else if (commit_except.load_pagefault) begin
            trap_cause = XLEN'(13);
        end else if (commit_except.store_pagefault) begin
            trap_cause = XLEN'(15);
        end else if (commit_except.load_access_fault) begin
            trap_cause = XLEN'(5);
        end else if (commit_except.store_access_fault) begin
            trap_cause = XLEN'(7);
        end
    end

    assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign trap_target = (mtvec_q[1:0] == 2'b01 && trap_irq) ? mtvec_base + XLEN'(28)
                                                             : mtvec_base;
    assign mtvec_wval  = {csr_wdata[XLEN-1:2], (csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
    assign trap_target = mtvec_base;
    assign mtvec_wval  = {csr_wdata[XLEN-1:2], 2'b00};
`endif

    // ------------------------------------------------------------------
    // CSR state; trap/mret updates are placed after the CSR write so they
    // take precedence when both touch the same register in one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie   <= 1'b0;
            mstatus_mpie  <= 1'b0;
            mie_mtie      <= 1'b0;
`ifdef TRAP_VECTORED_EN
            mtvec_q       <= RESET_MTVEC;
`else
            mtvec_q       <= {RESET_MTVEC[XLEN-1:2], 2'b00};
`endif
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= csr_wdata[3];
                        mstatus_mpie <= csr_wdata[7];
                    end
                    ADDR_MIE:    mie_mtie <= csr_wdata[7];
                    ADDR_MTVEC:  mtvec_q  <= mtvec_wval;
                    ADDR_MEPC:   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE: mcause_q <= csr_wdata;
                    ADDR_MTVAL:  mtval_q  <= csr_wdata;
                    default: ;
                endcase
            end
            if (take_trap) begin
                mepc_q        <= {commit_pc[XLEN-1:2], 2'b00};
                mcause_q      <= trap_cause;
                mtval_q       <= trap_tval;
                mstatus_mpie  <= mstatus_mie;
                mstatus_mie   <= 1'b0;
                redirect_pc_q <= trap_target;
            end else if (take_mret) begin
                mstatus_mie   <= mstatus_mpie;
                mstatus_mpie  <= 1'b1;
                redirect_pc_q <= mepc_q;
            end
        end
    end

    assign redirect_pc = redirect_pc_q;

    // ------------------------------------------------------------------
    // Flush / redirect sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        commit_ready   = 1'b0;
        flush_req      = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            S_IDLE: begin
                commit_ready = ~rst;
                if (take_trap || take_mret) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_req = 1'b1;
                if (flush_ack) begin
                    state_next = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // CSR read
    // ------------------------------------------------------------------
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[3]     = mstatus_mie;
                csr_rdata[7]     = mstatus_mpie;
                csr_rdata[12:11] = 2'b11;
            end
            ADDR_MIE:    csr_rdata[7] = mie_mtie;
            ADDR_MTVEC:  csr_rdata    = mtvec_q;
            ADDR_MEPC:   csr_rdata    = mepc_q;
            ADDR_MCAUSE: csr_rdata    = mcause_q;
            ADDR_MTVAL:  csr_rdata    = mtval_q;
            ADDR_MIP:    csr_rdata[7] = commit_except.timer_int;
            default:     csr_rdata    = '0;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl.
// Table of trap vectors plus hand-written sequences for timer gating,
// vectored mode, mret, back-pressure, CSR write collisions and reset
// during a flush. Expected redirect/CSR results are queued at commit and
// popped when the redirect strobe appears.

module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam logic [15:0] X_TIMER = 16'h8000;
    localparam logic [15:0] X_BRK   = 16'h4000;
    localparam logic [15:0] X_FPF   = 16'h2000;
    localparam logic [15:0] X_FAF   = 16'h1000;
    localparam logic [15:0] X_ILL   = 16'h0800;
    localparam logic [15:0] X_SRET  = 16'h0400;
    localparam logic [15:0] X_URET  = 16'h0200;
    localparam logic [15:0] X_FMIS  = 16'h0100;
    localparam logic [15:0] X_ECALL = 16'h0080;
    localparam logic [15:0] X_LMIS  = 16'h0040;
    localparam logic [15:0] X_SMIS  = 16'h0020;
    localparam logic [15:0] X_LPF   = 16'h0010;
    localparam logic [15:0] X_SPF   = 16'h0008;
    localparam logic [15:0] X_LAF   = 16'h0004;
    localparam logic [15:0] X_SAF   = 16'h0002;
    localparam logic [15:0] X_MRET  = 16'h0001;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    except_t     commit_except;
    logic [31:0] commit_tval;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        flush_req;
    logic        flush_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32), .RESET_MTVEC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_ready   (commit_ready),
        .commit_pc      (commit_pc),
        .commit_except  (commit_except),
        .commit_tval    (commit_tval),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .flush_req      (flush_req),
        .flush_ack      (flush_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] target;
        logic [31:0] cause;
        logic [31:0] mepc;
        logic [31:0] mtval;
    } exp_t;

    typedef struct {
        logic [15:0] e;
        logic [31:0] pc;
        logic [31:0] tval;
        int          ack_delay;
        bit          evt;
        logic [31:0] cause;
        logic [31:0] mtval;
        logic [31:0] target;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic csr_chk(input string nm, input logic [11:0] a, input logic [31:0] req);
        logic [31:0] d;
        csr_rd(a, d);
        check(nm, d, req);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    // Commit one instruction and walk the flush/redirect handshake.
    task automatic do_event(input string nm, input logic [15:0] e, input logic [31:0] pc,
                            input logic [31:0] tval, input int ack_delay, input bit evt,
                            input exp_t ex);
        exp_t got;
        check({nm, " ready"}, {31'b0, commit_ready}, 32'd1);
        commit_valid  = 1'b1;
        commit_except = except_t'(e);
        commit_pc     = pc;
        commit_tval   = tval;
        if (evt) sb.push_back(ex);
        tick();
        commit_valid  = 1'b0;
        commit_except = except_t'(16'h0);
        if (!evt) begin
            check({nm, " noflush"}, {31'b0, flush_req}, 32'd0);
            tick();
            check({nm, " noflush2"}, {31'b0, flush_req}, 32'd0);
            return;
        end
        check({nm, " flush"}, {31'b0, flush_req}, 32'd1);
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            check({nm, " flush_hold"}, {31'b0, flush_req}, 32'd1);
        end
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        check({nm, " redir_valid"}, {31'b0, redirect_valid}, 32'd1);
        got = sb.pop_front();
        if (redirect_valid) begin
            check({nm, " redir_pc"}, redirect_pc, got.target);
        end
        tick();
        check({nm, " redir_once"}, {31'b0, redirect_valid}, 32'd0);
        check({nm, " ready_again"}, {31'b0, commit_ready}, 32'd1);
        csr_chk({nm, " mcause"}, A_MCAUSE, got.cause);
        csr_chk({nm, " mepc"}, A_MEPC, got.mepc);
        csr_chk({nm, " mtval"}, A_MTVAL, got.mtval);
        // Recover from a stuck sequencer so later checks still run.
        for (int i = 0; i < 8 && !commit_ready; i++) begin
            flush_ack = 1'b1;
            tick();
        end
        flush_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        ex;
        logic [31:0] last_cause;
        logic [31:0] last_mepc;
        logic [31:0] last_mtval;
        logic [31:0] vec_target;
        logic [31:0] vec_mtvec;
        bit          saw_redir;

        vecs[0]  = '{X_ILL,                32'h8000_0100, 32'hFFFF_FFFF, 2, 1'b1, 32'd2,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[1]  = '{X_FPF|X_LMIS|X_MRET,  32'h8000_0104, 32'h0000_1234, 0, 1'b1, 32'd12, 32'h0000_1234, 32'h8000_0000};
        vecs[2]  = '{X_BRK|X_ECALL,        32'h8000_0203, 32'h0000_DEAD, 1, 1'b1, 32'd3,  32'h8000_0203, 32'h8000_0000};
        vecs[3]  = '{X_ECALL|X_SAF,        32'h8000_0300, 32'h0000_5555, 0, 1'b1, 32'd11, 32'h0,         32'h8000_0000};
        vecs[4]  = '{X_SRET,               32'h8000_0304, 32'h0000_7777, 1, 1'b1, 32'd2,  32'h0,         32'h8000_0000};
        vecs[5]  = '{X_URET|X_FMIS,        32'h8000_0308, 32'h0000_6666, 0, 1'b1, 32'd2,  32'h0,         32'h8000_0000};
        vecs[6]  = '{X_LAF|X_SAF,          32'h8000_030C, 32'h0000_A0A0, 0, 1'b1, 32'd5,  32'h0000_A0A0, 32'h8000_0000};
        vecs[7]  = '{X_SPF|X_LAF,          32'h8000_0310, 32'h0000_B0B0, 3, 1'b1, 32'd15, 32'h0000_B0B0, 32'h8000_0000};
        vecs[8]  = '{X_TIMER,              32'h8000_0314, 32'h0,         0, 1'b0, 32'd0,  32'h0,         32'h0};
        vecs[9]  = '{X_FMIS|X_ECALL,       32'h8000_0318, 32'h0000_C0C0, 0, 1'b1, 32'd0,  32'h0000_C0C0, 32'h8000_0000};
        vecs[10] = '{X_LPF|X_SPF,          32'h8000_031C, 32'h0000_D0D0, 0, 1'b1, 32'd13, 32'h0000_D0D0, 32'h8000_0000};
        vecs[11] = '{X_SMIS|X_LPF,         32'h8000_0320, 32'h0000_E0E0, 0, 1'b1, 32'd6,  32'h0000_E0E0, 32'h8000_0000};
        vecs[12] = '{X_FAF|X_ILL,          32'h8000_0324, 32'h0000_F0F0, 0, 1'b1, 32'd1,  32'h0000_F0F0, 32'h8000_0000};
        vecs[13] = '{X_LMIS|X_SMIS,        32'h8000_0329, 32'h0000_1111, 0, 1'b1, 32'd4,  32'h0000_1111, 32'h8000_0000};
        vecs[14] = '{16'h0,                32'h8000_0330, 32'h0000_2222, 0, 1'b0, 32'd0,  32'h0,         32'h0};
        vecs[15] = '{X_SAF,                32'h8000_0334, 32'h0000_3333, 1, 1'b1, 32'd7,  32'h0000_3333, 32'h8000_0000};

`ifdef TRAP_VECTORED_EN
        vec_target = 32'h8000_001C;
        vec_mtvec  = 32'h8000_0001;
`else
        vec_target = 32'h8000_0000;
        vec_mtvec  = 32'h8000_0000;
`endif

        rst           = 1'b1;
        commit_valid  = 1'b0;
        commit_pc     = '0;
        commit_except = except_t'(16'h0);
        commit_tval   = '0;
        csr_we        = 1'b0;
        csr_addr      = '0;
        csr_wdata     = '0;
        flush_ack     = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst ready", {31'b0, commit_ready}, 32'd0);
        check("rst flush", {31'b0, flush_req}, 32'd0);
        check("rst redir", {31'b0, redirect_valid}, 32'd0);
        check("rst redir_pc", redirect_pc, 32'h0);
        rst = 1'b0;
        tick();
        check("post-rst ready", {31'b0, commit_ready}, 32'd1);
        csr_chk("rst mstatus", A_MSTATUS, 32'h0000_1800);
        csr_chk("rst mie", A_MIE, 32'h0);
        csr_chk("rst mtvec", A_MTVEC, 32'h8000_0000);
        csr_chk("rst mepc", A_MEPC, 32'h0);
        tick();
        csr_chk("rst mcause", A_MCAUSE, 32'h0);
        csr_chk("rst mtval", A_MTVAL, 32'h0);
        csr_chk("unmapped", 12'h7C0, 32'h0);
        tick();

        // Table-driven trap vectors (direct mode, interrupts disabled)
        last_cause = '0;
        last_mepc  = '0;
        last_mtval = '0;
        foreach (vecs[i]) begin
            ex.target = vecs[i].target;
            ex.cause  = vecs[i].cause;
            ex.mepc   = vecs[i].pc & 32'hFFFF_FFFC;
            ex.mtval  = vecs[i].mtval;
            do_event($sformatf("vec%0d", i), vecs[i].e, vecs[i].pc, vecs[i].tval,
                     vecs[i].ack_delay, vecs[i].evt, ex);
            if (vecs[i].evt) begin
                last_cause = ex.cause;
                last_mepc  = ex.mepc;
                last_mtval = ex.mtval;
            end else begin
                csr_chk($sformatf("vec%0d mcause_kept", i), A_MCAUSE, last_cause);
                csr_chk($sformatf("vec%0d mepc_kept", i), A_MEPC, last_mepc);
                csr_chk($sformatf("vec%0d mtval_kept", i), A_MTVAL, last_mtval);
            end
            tick();
        end
        csr_chk("mstatus after traps", A_MSTATUS, 32'h0000_1800);

        // mip mirrors the timer input combinationally
        commit_except = except_t'(X_TIMER);
        csr_chk("mip set", A_MIP, 32'h0000_0080);
        commit_except = except_t'(16'h0);
        csr_chk("mip clr", A_MIP, 32'h0);
        tick();

        // Timer gating: MIE set but MTIE clear -> ignored
        csr_wr(A_MSTATUS, 32'h0000_0008);
        csr_chk("mstatus mie", A_MSTATUS, 32'h0000_1808);
        ex = '{32'h0, 32'h0, 32'h0, 32'h0};
        do_event("timer_mtie0", X_TIMER, 32'h8000_0400, 32'h0, 0, 1'b0, ex);
        csr_wr(A_MIE, 32'hFFFF_FFFF);
        csr_chk("mie rd", A_MIE, 32'h0000_0080);
        csr_wr(A_MTVEC, 32'h8000_0001);
        csr_chk("mtvec rd", A_MTVEC, vec_mtvec);
        ex = '{vec_target, 32'h8000_0007, 32'h8000_0400, 32'h0};
        do_event("timer", X_TIMER | X_ILL, 32'h8000_0402, 32'h0000_0055, 0, 1'b1, ex);
        csr_chk("timer mstatus", A_MSTATUS, 32'h0000_1880);

        // mret returns to mepc, restores MIE from MPIE, keeps mcause
        csr_wr(A_MEPC, 32'h8000_0200);
        ex = '{32'h8000_0200, 32'h8000_0007, 32'h8000_0200, 32'h0};
        do_event("mret", X_MRET, 32'h8000_0500, 32'h0000_9999, 0, 1'b1, ex);
        csr_chk("mret mstatus", A_MSTATUS, 32'h0000_1888);

        // Synchronous exception in vectored mode still goes to BASE
        ex = '{32'h8000_0000, 32'd2, 32'h8000_0504, 32'h0000_0BAD};
        do_event("vec_exc", X_ILL, 32'h8000_0504, 32'h0000_0BAD, 0, 1'b1, ex);
        csr_chk("vec_exc mstatus", A_MSTATUS, 32'h0000_1880);

        // Unsupported MODE value
        csr_wr(A_MTVEC, 32'h8000_0002);
        csr_chk("mtvec mode2", A_MTVEC, 32'h8000_0000);
        csr_wr(A_MTVEC, 32'h8000_0000);

        // mepc low bits forced to zero
        csr_wr(A_MEPC, 32'h0000_0123);
        csr_chk("mepc align", A_MEPC, 32'h0000_0120);
        tick();

        // Back-pressure, write collision and writes during FLUSH
        commit_valid  = 1'b1;
        commit_except = except_t'(X_ILL);
        commit_pc     = 32'h8000_0600;
        commit_tval   = 32'h0000_0077;
        csr_we        = 1'b1;
        csr_addr      = A_MCAUSE;
        csr_wdata     = 32'h0000_0055;
        tick();
        csr_we        = 1'b0;
        commit_except = except_t'(X_BRK);
        commit_pc     = 32'h8000_0700;
        check("bp ready flush", {31'b0, commit_ready}, 32'd0);
        check("bp flush", {31'b0, flush_req}, 32'd1);
        csr_wr(A_MTVAL, 32'h0000_ABCD);
        check("bp ready flush2", {31'b0, commit_ready}, 32'd0);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        check("bp redir", {31'b0, redirect_valid}, 32'd1);
        check("bp ready redir", {31'b0, commit_ready}, 32'd0);
        check("bp redir_pc", redirect_pc, 32'h8000_0000);
        commit_valid  = 1'b0;
        commit_except = except_t'(16'h0);
        tick();
        check("bp ready idle", {31'b0, commit_ready}, 32'd1);
        csr_chk("bp mepc", A_MEPC, 32'h8000_0600);
        csr_chk("bp mcause", A_MCAUSE, 32'd2);
        csr_chk("bp mtval", A_MTVAL, 32'h0000_ABCD);
        tick();

        // flush_ack outside FLUSH is ignored
        flush_ack = 1'b1;
        tick();
        tick();
        check("stray ack redir", {31'b0, redirect_valid}, 32'd0);
        check("stray ack flush", {31'b0, flush_req}, 32'd0);
        flush_ack = 1'b0;
        tick();

        // Reset during FLUSH
        commit_valid  = 1'b1;
        commit_except = except_t'(X_ECALL);
        commit_pc     = 32'h8000_0800;
        tick();
        commit_valid  = 1'b0;
        commit_except = except_t'(16'h0);
        check("rstfl flush", {31'b0, flush_req}, 32'd1);
        rst       = 1'b1;
        flush_ack = 1'b1;
        tick();
        rst       = 1'b0;
        check("rstfl flush drop", {31'b0, flush_req}, 32'd0);
        check("rstfl redir_pc", redirect_pc, 32'h0);
        saw_redir = redirect_valid;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (redirect_valid) saw_redir = 1'b1;
        end
        flush_ack = 1'b0;
        check("rstfl no redir", {31'b0, saw_redir}, 32'd0);
        check("rstfl ready", {31'b0, commit_ready}, 32'd1);
        csr_chk("rstfl mstatus", A_MSTATUS, 32'h0000_1800);
        csr_chk("rstfl mie", A_MIE, 32'h0);
        csr_chk("rstfl mtvec", A_MTVEC, 32'h8000_0000);
        csr_chk("rstfl mepc", A_MEPC, 32'h0);
        tick();
        csr_chk("rstfl mcause", A_MCAUSE, 32'h0);
        csr_chk("rstfl mtval", A_MTVAL, 32'h0);

        check("scoreboard empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
